vend_txn_controller: RTL and testbench
======================================

// Module: vend_txn_controller
// PURPOSE
//   Transaction sequencer for the drink vending datapath. Accepts coins into a credit register and checks a drink
//   selection against per-drink prices. Drives the dispense mechanism through a req/ack handshake, then pays out
//   change one coin at a time to the coin hopper (greedy 50/10/5/1). A cancel refunds all credit through the same path.
// PARAMETERS
//   CREDIT_W    7   width of credit and coin values
//   MAX_CREDIT  99  coin rejected if credit+coin would exceed this
//   PRICE_TEA   10  price, drink code 3'b001
//   PRICE_COKE  15  price, drink code 3'b010
//   PRICE_COFF  20  price, drink code 3'b011
//   PRICE_MILK  25  price, drink code 3'b100
// PORTS
//   clk          in   1         rising-edge clock
//   reset        in   1         reset, synchronous, active-high
//   coin_valid   in   1         one-cycle strobe, coin inserted
//   coin_value   in   CREDIT_W  coin value; only 1,5,10,50 are legal
//   sel_valid    in   1         one-cycle strobe, drink selected
//   sel          in   3         drink code (001 tea,010 coke,011 coffee,100 milk)
//   cancel       in   1         one-cycle strobe, refund all credit
//   drink_req    out  1         dispense request, held until drink_ack
//   drink_code   out  3         drink to dispense, stable while drink_req
//   drink_ack    in   1         dispenser done
//   pay_valid    out  1         payout coin request, held until pay_ready
//   pay_coin     out  CREDIT_W  denomination to eject, stable while pay_valid
//   pay_ready    in   1         hopper ejected the coin
//   coin_reject  out  1         one-cycle pulse, last coin returned unaccepted
//   insufficient out  1         one-cycle pulse, selection price > credit
//   credit       out  CREDIT_W  current credit
//   busy         out  1         state != IDLE
//   vend_done    out  1         one-cycle pulse, vend transaction finished
//   refund_done  out  1         one-cycle pulse, cancel refund finished
// BEHAVIOUR
//   Reset: state=IDLE; credit=0; every output 0. Reset mid-transaction abandons it; outstanding req/valid drop next cycle.
//   All outputs are registered; a strobe at edge n is reflected at edge n+1.
//   FSM IDLE -> VEND -> CHANGE -> DONE -> IDLE. The cancel path is IDLE -> CHANGE -> DONE.
//   IDLE (per-cycle priority; a lower item is ignored if a higher one fires):
//     1) cancel & credit>0 -> CHANGE, mark refund. cancel with credit==0 is ignored.
//     2) coin_valid: legal and credit+coin<=MAX_CREDIT -> credit+=coin; otherwise coin_reject=1.
//     3) sel_valid, code 001..100: price<=credit -> VEND, drink_code=sel, mark vend; otherwise insufficient=1.
//        Codes 000 and 101..111 are ignored.
//   VEND: drink_req=1. On drink_ack: credit-=price, drink_req=0.
//     Next state is CHANGE if the remainder is >0, else DONE.
//   CHANGE: pay_valid=1, pay_coin = largest of {50,10,5,1} <= credit.
//     On pay_valid&pay_ready: credit-=pay_coin. Then DONE if credit becomes 0; else the next coin is presented
//     next cycle, with pay_valid deasserted for 1 cycle between coins.
//   DONE: one cycle; vend_done or refund_done per mark; -> IDLE.
//   Outside IDLE: any coin_valid -> coin_reject pulse, credit unchanged. sel_valid and cancel are ignored.
//   Acks/readies arriving without a matching req/valid are ignored.
//   Credit never wraps: bounded by MAX_CREDIT and never decremented below 0.
// TESTING
//   1) coins 10,1,5 then sel=001 -> credit 16; drink_req/code 001; after ack credit 6.
//      Payout 5 then 1; vend_done; credit 0.
//   2) coins 5,5,1,1,10 (credit 22), sel=100 -> insufficient pulse, stays IDLE.
//      Then cancel -> payout 10,10,1,1; refund_done.
//   3) coin 10, sel=001 -> exact change: drink_req, ack -> DONE with no pay_valid; vend_done.
//   4) coin 50 twice -> second rejected (100>99), credit 50. coin_value=7 -> coin_reject, credit unchanged.
//   5) coin_valid with sel_valid same cycle -> coin credited, selection dropped.
//      Coin during VEND -> coin_reject. pay_ready held low 5 cycles -> pay_valid/pay_coin stable.
//   6) reset asserted during CHANGE -> next cycle all outputs 0, credit 0, busy 0; a new coin is accepted normally.

Source files
------------

// File: rtl/vend_txn_if.sv
// vend_txn_if: coin, selection, dispense and payout signals of the vending sequencer
interface vend_txn_if #(parameter int CREDIT_W = 7);
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                sel_valid;
  logic [2:0]          sel;
  logic                cancel;
  logic                drink_req;
  logic [2:0]          drink_code;
  logic                drink_ack;
  logic                pay_valid;
  logic [CREDIT_W-1:0] pay_coin;
  logic                pay_ready;
  logic                coin_reject;
  logic                insufficient;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                vend_done;
  logic                refund_done;
  modport master (
    output coin_valid, coin_value, sel_valid, sel, cancel, drink_ack, pay_ready,
    input  drink_req, drink_code, pay_valid, pay_coin, coin_reject, insufficient, credit, busy, vend_done, refund_done
  );
  modport slave (
    input  coin_valid, coin_value, sel_valid, sel, cancel, drink_ack, pay_ready,
    output drink_req, drink_code, pay_valid, pay_coin, coin_reject, insufficient, credit, busy, vend_done, refund_done
  );
endinterface

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: coin credit, drink vend handshake and greedy change/refund payout
module vend_txn_controller #(
  parameter int CREDIT_W   = 7,
  parameter int MAX_CREDIT = 99,
  parameter int PRICE_TEA  = 10,
  parameter int PRICE_COKE = 15,
  parameter int PRICE_COFF = 20,
  parameter int PRICE_MILK = 25
) (
  input logic       clk,
  input logic       reset,
  vend_txn_if.slave bus
);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE, DONE} state_t;
  typedef logic [CREDIT_W-1:0] val_t;
  typedef logic [CREDIT_W:0]   sum_t;
  state_t     state, state_n;
  val_t       credit, credit_n, pay_coin, pay_coin_n;
  logic [2:0] drink_code, drink_code_n;
  logic       drink_req, pay_valid, coin_reject, insufficient, vend_done, refund_done, busy, mark;
  logic       drink_req_n, pay_valid_n, coin_reject_n, insufficient_n, vend_done_n, refund_done_n, busy_n, mark_n;
  logic       idle, do_cancel, coin_ok, sel_known, do_sel, acked, paid;
  val_t       sel_price, cur_price, next_coin;
  sum_t       coin_sum;

  function automatic val_t price_of(input logic [2:0] c);
    return c == 3'd1 ? val_t'(PRICE_TEA) : c == 3'd2 ? val_t'(PRICE_COKE) :
           c == 3'd3 ? val_t'(PRICE_COFF) : val_t'(PRICE_MILK);
  endfunction

  assign idle      = state == IDLE;
  assign do_cancel = idle && bus.cancel && credit != '0;
  assign coin_sum  = {1'b0, credit} + {1'b0, bus.coin_value};
  assign coin_ok   = (bus.coin_value == val_t'(1) || bus.coin_value == val_t'(5) ||
                      bus.coin_value == val_t'(10) || bus.coin_value == val_t'(50)) &&
                     coin_sum <= sum_t'(MAX_CREDIT);
  assign sel_known = bus.sel >= 3'd1 && bus.sel <= 3'd4;
  assign sel_price = price_of(bus.sel);
  assign do_sel    = idle && !do_cancel && !bus.coin_valid && bus.sel_valid && sel_known && sel_price <= credit;
  assign cur_price = price_of(drink_code);
  assign acked     = drink_req && bus.drink_ack;
  assign paid      = pay_valid && bus.pay_ready;
  assign next_coin = credit >= val_t'(50) ? val_t'(50) : credit >= val_t'(10) ? val_t'(10) :
                     credit >= val_t'(5) ? val_t'(5) : val_t'(1);

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= '0;
      pay_coin     <= '0;
      drink_code   <= '0;
      drink_req    <= 1'b0;
      pay_valid    <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      vend_done    <= 1'b0;
      refund_done  <= 1'b0;
      busy         <= 1'b0;
      mark         <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      pay_coin     <= pay_coin_n;
      drink_code   <= drink_code_n;
      drink_req    <= drink_req_n;
      pay_valid    <= pay_valid_n;
      coin_reject  <= coin_reject_n;
      insufficient <= insufficient_n;
      vend_done    <= vend_done_n;
      refund_done  <= refund_done_n;
      busy         <= busy_n;
      mark         <= mark_n;
    end
  end

  // transaction sequencing: cancel beats coin beats selection while idle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = do_cancel ? CHANGE : do_sel ? VEND : IDLE;
      VEND:    state_n = !acked ? VEND : credit == cur_price ? DONE : CHANGE;
      CHANGE:  state_n = paid && credit == pay_coin ? DONE : CHANGE;
      default: state_n = IDLE;
    endcase
  end

  // next values of credit and outputs; payout alternates present/accept so coins are separated by a gap
  always_comb begin
    credit_n       = (idle && !do_cancel && bus.coin_valid && coin_ok) ? coin_sum[CREDIT_W-1:0] :
                     acked ? credit - cur_price : paid ? credit - pay_coin : credit;
    coin_reject_n  = bus.coin_valid && !(idle && !do_cancel && coin_ok);
    insufficient_n = idle && !do_cancel && !bus.coin_valid && bus.sel_valid && sel_known && sel_price > credit;
    drink_req_n    = state_n == VEND;
    drink_code_n   = do_sel ? bus.sel : drink_code;
    pay_valid_n    = state == CHANGE && (!pay_valid || !bus.pay_ready);
    pay_coin_n     = (state == CHANGE && !pay_valid) ? next_coin : pay_coin;
    mark_n         = do_cancel ? 1'b0 : do_sel ? 1'b1 : mark;
    vend_done_n    = state_n == DONE && mark_n;
    refund_done_n  = state_n == DONE && !mark_n;
    busy_n         = state_n != IDLE;
  end

  assign bus.credit       = credit;
  assign bus.pay_coin     = pay_coin;
  assign bus.drink_code   = drink_code;
  assign bus.drink_req    = drink_req;
  assign bus.pay_valid    = pay_valid;
  assign bus.coin_reject  = coin_reject;
  assign bus.insufficient = insufficient;
  assign bus.vend_done    = vend_done;
  assign bus.refund_done  = refund_done;
  assign bus.busy         = busy;
endmodule

// File: tb/tb_vend_txn_controller.sv
// tb_vend_txn_controller: directed scenarios plus randomized transactions against a credit/change model
module tb_vend_txn_controller;
  logic clk = 0;
  logic reset = 0;
  int   tests = 0;
  int   fails = 0;
  int   cred = 0;
  int   got[$];
  int   exp_q[$];
  int   prices[5] = '{0, 10, 15, 20, 25};
  int   legal[4] = '{1, 5, 10, 50};

  vend_txn_if #(.CREDIT_W(7)) b();
  vend_txn_controller dut (.clk(clk), .reset(reset), .bus(b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  function automatic void expect_change(input int amt);
    exp_q.delete();
    repeat (amt / 50) exp_q.push_back(50);
    repeat ((amt % 50) / 10) exp_q.push_back(10);
    repeat ((amt % 10) / 5) exp_q.push_back(5);
    repeat (amt % 5) exp_q.push_back(1);
  endfunction

  function automatic bit same_q();
    if (got.size() != exp_q.size()) return 0;
    foreach (got[i]) if (got[i] != exp_q[i]) return 0;
    return 1;
  endfunction

  task automatic put_coin(input int v, output logic rej, output int cr);
    b.coin_valid = 1; b.coin_value = 7'(v);
    @(negedge clk);
    rej = b.coin_reject; cr = int'(b.credit);
    b.coin_valid = 0;
  endtask

  task automatic pick(input int s, output logic ins, output logic req, output logic [2:0] code, output logic bz);
    b.sel_valid = 1; b.sel = 3'(s);
    @(negedge clk);
    ins = b.insufficient; req = b.drink_req; code = b.drink_code; bz = b.busy;
    b.sel_valid = 0;
  endtask

  task automatic press_cancel();
    b.cancel = 1;
    @(negedge clk);
    b.cancel = 0;
  endtask

  task automatic serve(input int maxd, output logic [2:0] code, output logic vd, output logic rd, output logic to);
    int w;
    w = $urandom_range(0, maxd); code = 0; vd = 0; rd = 0; to = 1; got.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      b.drink_ack = 0; b.pay_ready = 0;
      if (b.vend_done || b.refund_done) begin vd = b.vend_done; rd = b.refund_done; to = 0; break; end
      if (b.drink_req || b.pay_valid) begin
        if (b.drink_req) code = b.drink_code;
        if (w == 0) begin
          if (b.drink_req) b.drink_ack = 1;
          else begin b.pay_ready = 1; got.push_back(int'(b.pay_coin)); end
          w = $urandom_range(0, maxd);
        end else w--;
      end else begin
        b.drink_ack = $urandom_range(0, 3) == 0;
        b.pay_ready = $urandom_range(0, 3) == 0;
      end
    end
    b.drink_ack = 0; b.pay_ready = 0;
  endtask

  task automatic wait_pay(output logic to);
    to = 1;
    for (int c = 0; c < 20 && to; c++) begin
      if (b.pay_valid) to = 0; else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    tests++; if ({b.drink_req, b.drink_code, b.pay_valid, b.pay_coin, b.coin_reject, b.insufficient, b.credit, b.busy, b.vend_done, b.refund_done} !== 24'h0) begin
      fails++; $display("FAIL reset_outputs: got %h want 000000", {b.drink_req, b.drink_code, b.pay_valid, b.pay_coin, b.coin_reject, b.insufficient, b.credit, b.busy, b.vend_done, b.refund_done}); end
    reset = 0;
    @(negedge clk);
    tests++; if (b.busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b want 0", b.busy); end
  endtask

  task automatic test_vend_change();
    logic rej, ins, req, bz, vd, rd, to; logic [2:0] code; int cr;
    put_coin(10, rej, cr); put_coin(1, rej, cr); put_coin(5, rej, cr);
    tests++; if (rej !== 1'b0 || cr != 16) begin fails++; $display("FAIL vend_credit: got rej=%b credit=%0d want rej=0 credit=16", rej, cr); end
    pick(1, ins, req, code, bz);
    tests++; if (req !== 1'b1 || code !== 3'b001 || ins !== 1'b0 || bz !== 1'b1) begin
      fails++; $display("FAIL vend_req: got req=%b code=%b ins=%b busy=%b want 1 001 0 1", req, code, ins, bz); end
    b.drink_ack = 1; @(negedge clk); b.drink_ack = 0;
    tests++; if (b.credit !== 7'd6 || b.drink_req !== 1'b0) begin
      fails++; $display("FAIL vend_after_ack: got credit=%0d req=%b want 6 0", b.credit, b.drink_req); end
    serve(2, code, vd, rd, to);
    expect_change(6);
    tests++; if (!same_q() || vd !== 1'b1 || rd !== 1'b0 || to) begin
      fails++; $display("FAIL vend_payout: got %p vd=%b rd=%b to=%b want %p vd=1 rd=0 to=0", got, vd, rd, to, exp_q); end
    @(negedge clk);
    tests++; if (b.credit !== 7'd0 || b.busy !== 1'b0) begin fails++; $display("FAIL vend_end: got credit=%0d busy=%b want 0 0", b.credit, b.busy); end
  endtask

  task automatic test_insufficient_cancel();
    logic rej, ins, req, bz, vd, rd, to; logic [2:0] code; int cr;
    put_coin(5, rej, cr); put_coin(5, rej, cr); put_coin(1, rej, cr); put_coin(1, rej, cr); put_coin(10, rej, cr);
    tests++; if (cr != 22) begin fails++; $display("FAIL insuf_credit: got %0d want 22", cr); end
    pick(4, ins, req, code, bz);
    tests++; if (ins !== 1'b1 || req !== 1'b0 || bz !== 1'b0) begin
      fails++; $display("FAIL insuf_pulse: got ins=%b req=%b busy=%b want 1 0 0", ins, req, bz); end
    @(negedge clk);
    tests++; if (b.insufficient !== 1'b0 || b.credit !== 7'd22) begin
      fails++; $display("FAIL insuf_one_cycle: got ins=%b credit=%0d want 0 22", b.insufficient, b.credit); end
    press_cancel();
    serve(3, code, vd, rd, to);
    expect_change(22);
    tests++; if (!same_q() || rd !== 1'b1 || vd !== 1'b0 || to) begin
      fails++; $display("FAIL refund_payout: got %p rd=%b vd=%b to=%b want %p rd=1 vd=0 to=0", got, rd, vd, to, exp_q); end
    @(negedge clk);
  endtask

  task automatic test_exact();
    logic rej, ins, req, bz, vd, rd, to; logic [2:0] code; int cr;
    put_coin(10, rej, cr);
    pick(1, ins, req, code, bz);
    serve(2, code, vd, rd, to);
    tests++; if (got.size() != 0 || vd !== 1'b1 || code !== 3'b001 || to) begin
      fails++; $display("FAIL exact_change: got coins=%p vd=%b code=%b to=%b want none 1 001 0", got, vd, code, to); end
    @(negedge clk);
  endtask

  task automatic test_reject();
    logic rej, vd, rd, to; logic [2:0] code; int cr;
    put_coin(50, rej, cr);
    put_coin(50, rej, cr);
    tests++; if (rej !== 1'b1 || cr != 50) begin fails++; $display("FAIL reject_over: got rej=%b credit=%0d want 1 50", rej, cr); end
    put_coin(7, rej, cr);
    tests++; if (rej !== 1'b1 || cr != 50) begin fails++; $display("FAIL reject_illegal: got rej=%b credit=%0d want 1 50", rej, cr); end
    @(negedge clk);
    tests++; if (b.coin_reject !== 1'b0) begin fails++; $display("FAIL reject_pulse: got %b want 0", b.coin_reject); end
    press_cancel();
    serve(1, code, vd, rd, to);
    expect_change(50);
    tests++; if (!same_q() || rd !== 1'b1 || to) begin fails++; $display("FAIL reject_refund: got %p rd=%b want %p rd=1", got, rd, exp_q); end
    @(negedge clk);
  endtask

  task automatic test_priority_stall();
    logic rej, ins, req, bz, to, stable; logic [2:0] code; int cr;
    put_coin(10, rej, cr);
    b.coin_valid = 1; b.coin_value = 7'd5; b.sel_valid = 1; b.sel = 3'd1;
    @(negedge clk);
    b.coin_valid = 0; b.sel_valid = 0;
    tests++; if (b.credit !== 7'd15 || b.drink_req !== 1'b0 || b.busy !== 1'b0 || b.insufficient !== 1'b0) begin
      fails++; $display("FAIL prio_coin_over_sel: got credit=%0d req=%b busy=%b want 15 0 0", b.credit, b.drink_req, b.busy); end
    pick(1, ins, req, code, bz);
    press_cancel();
    tests++; if (b.drink_req !== 1'b1 || b.busy !== 1'b1 || b.credit !== 7'd15) begin
      fails++; $display("FAIL cancel_in_vend: got req=%b busy=%b credit=%0d want 1 1 15", b.drink_req, b.busy, b.credit); end
    put_coin(5, rej, cr);
    tests++; if (rej !== 1'b1 || cr != 15) begin fails++; $display("FAIL coin_in_vend: got rej=%b credit=%0d want 1 15", rej, cr); end
    b.drink_ack = 1; @(negedge clk); b.drink_ack = 0;
    wait_pay(to);
    tests++; if (to) begin fails++; $display("FAIL stall_pay_timeout: got no pay_valid want pay_valid"); end
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      stable &= b.pay_valid === 1'b1 && b.pay_coin === 7'd5;
    end
    tests++; if (!stable) begin fails++; $display("FAIL stall_stable: got valid=%b coin=%0d want 1 5", b.pay_valid, b.pay_coin); end
    b.pay_ready = 1; @(negedge clk); b.pay_ready = 0;
    tests++; if (b.vend_done !== 1'b1 || b.credit !== 7'd0 || b.pay_valid !== 1'b0) begin
      fails++; $display("FAIL stall_done: got vd=%b credit=%0d valid=%b want 1 0 0", b.vend_done, b.credit, b.pay_valid); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic rej, vd, rd, to; logic [2:0] code; int cr;
    put_coin(50, rej, cr); put_coin(10, rej, cr); put_coin(5, rej, cr);
    press_cancel();
    wait_pay(to);
    tests++; if (to) begin fails++; $display("FAIL midreset_pay_timeout: got no pay_valid want pay_valid"); end
    reset = 1; @(negedge clk); reset = 0;
    tests++; if ({b.drink_req, b.drink_code, b.pay_valid, b.pay_coin, b.coin_reject, b.insufficient, b.credit, b.busy, b.vend_done, b.refund_done} !== 24'h0) begin
      fails++; $display("FAIL midreset_outputs: got %h want 000000", {b.drink_req, b.drink_code, b.pay_valid, b.pay_coin, b.coin_reject, b.insufficient, b.credit, b.busy, b.vend_done, b.refund_done}); end
    put_coin(5, rej, cr);
    tests++; if (rej !== 1'b0 || cr != 5) begin fails++; $display("FAIL midreset_new_coin: got rej=%b credit=%0d want 0 5", rej, cr); end
    press_cancel();
    serve(1, code, vd, rd, to);
    tests++; if (rd !== 1'b1 || got.size() != 1 || to) begin fails++; $display("FAIL midreset_refund: got %p rd=%b want {5} rd=1", got, rd); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic rej, ins, req, bz, vd, rd, to; logic [2:0] code; int cr, op, v, s;
    cred = 0;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        v = $urandom_range(0, 9) < 8 ? legal[$urandom_range(0, 3)] : $urandom_range(0, 127);
        put_coin(v, rej, cr);
        if ((v == 1 || v == 5 || v == 10 || v == 50) && cred + v <= 99) begin
          cred += v;
          tests++; if (rej !== 1'b0 || cr != cred) begin fails++; $display("FAIL rnd_coin_accept v=%0d: got rej=%b credit=%0d want 0 %0d", v, rej, cr, cred); end
        end else begin
          tests++; if (rej !== 1'b1 || cr != cred) begin fails++; $display("FAIL rnd_coin_reject v=%0d: got rej=%b credit=%0d want 1 %0d", v, rej, cr, cred); end
        end
      end else if (op <= 8) begin
        s = $urandom_range(0, 7);
        pick(s, ins, req, code, bz);
        if (s >= 1 && s <= 4 && prices[s] <= cred) begin
          tests++; if (req !== 1'b1 || code !== 3'(s) || ins !== 1'b0) begin
            fails++; $display("FAIL rnd_sel_req s=%0d: got req=%b code=%b ins=%b want 1 %0d 0", s, req, code, ins, s); end
          serve(3, code, vd, rd, to);
          expect_change(cred - prices[s]);
          tests++; if (!same_q() || vd !== 1'b1 || rd !== 1'b0 || code !== 3'(s) || to) begin
            fails++; $display("FAIL rnd_vend s=%0d credit=%0d: got %p vd=%b to=%b want %p vd=1", s, cred, got, vd, to, exp_q); end
          cred = 0;
          @(negedge clk);
          tests++; if (b.busy !== 1'b0 || b.credit !== 7'd0) begin fails++; $display("FAIL rnd_vend_idle: got busy=%b credit=%0d want 0 0", b.busy, b.credit); end
        end else begin
          tests++; if (req !== 1'b0 || bz !== 1'b0 || ins !== (s >= 1 && s <= 4)) begin
            fails++; $display("FAIL rnd_sel_none s=%0d credit=%0d: got req=%b busy=%b ins=%b", s, cred, req, bz, ins); end
        end
      end else begin
        press_cancel();
        if (cred > 0) begin
          serve(3, code, vd, rd, to);
          expect_change(cred);
          tests++; if (!same_q() || rd !== 1'b1 || vd !== 1'b0 || to) begin
            fails++; $display("FAIL rnd_refund credit=%0d: got %p rd=%b to=%b want %p rd=1", cred, got, rd, to, exp_q); end
          cred = 0;
          @(negedge clk);
        end else begin
          tests++; if (b.busy !== 1'b0 || b.refund_done !== 1'b0) begin fails++; $display("FAIL rnd_cancel_empty: got busy=%b rd=%b want 0 0", b.busy, b.refund_done); end
        end
      end
    end
  endtask

  initial begin
    b.coin_valid = 0; b.coin_value = 0; b.sel_valid = 0; b.sel = 0; b.cancel = 0; b.drink_ack = 0; b.pay_ready = 0;
    @(negedge clk);
    test_reset();
    test_vend_change();
    test_insufficient_cancel();
    test_exact();
    test_reject();
    test_priority_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
